// File: rtl/round_sequencer.sv
// Session sequencer for the binary-math game: start, per-question operand/timer
// handshakes, scoring, round count and logout. Optional strike limit: STRIKE_LIMIT_EN.
module round_sequencer #(
  parameter int ROUNDS   = 10,
  parameter int MAX_MISS = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Access,
  input  logic       Button,
  input  logic [4:0] Answer,
  input  logic [4:0] Expected,
  input  logic       TimeUp,
  output logic       RNGOut,
  output logic       LoadOut,
  output logic       Enable,
  output logic       Correct,
  output logic       Wrong,
  output logic [4:0] Score,
  output logic [4:0] Round,
  output logic       GameOver,
  output logic       LogOut
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_CHECK = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  state_t     state_q, state_d;
  logic [4:0] score_q, score_d;
  logic [4:0] round_q, round_d;
  logic [4:0] ans_q, ans_d;
  logic       rng_q, rng_d;
  logic       load_q, load_d;
  logic       enable_q, enable_d;
  logic       correct_q, correct_d;
  logic       wrong_q, wrong_d;
  logic       game_over_q, game_over_d;
  logic       logout_q, logout_d;
  logic       strike_hit_s;

`ifdef STRIKE_LIMIT_EN
  localparam logic [4:0] MISS_LIMIT = 5'(MAX_MISS);
  logic [4:0] miss_q, miss_d;

  // Consecutive-miss counter: cleared on start and on a correct answer.
  always_comb begin
    miss_d = miss_q;
    if ((state_q == S_IDLE) && (state_d == S_GEN)) begin
      miss_d = 5'd0;
    end else if ((state_q == S_PLAY) && (state_d == S_NEXT)) begin
      miss_d = sat_inc(miss_q);
    end else if ((state_q == S_CHECK) && (state_d == S_NEXT)) begin
      miss_d = (ans_q == Expected) ? 5'd0 : sat_inc(miss_q);
    end else begin
      miss_d = miss_q;
    end
  end

  // Miss counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      miss_q <= 5'd0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign strike_hit_s = (miss_q == MISS_LIMIT);
`else
  assign strike_hit_s = 1'b0;
`endif

  // Next-state, score and round bookkeeping.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    round_d = round_q;
    ans_d   = ans_q;
    // Losing access aborts the session from anywhere; Score/Round are kept.
    if ((state_q != S_IDLE) && !Access) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Access && Button) begin
            score_d = 5'd0;
            round_d = 5'd0;
            state_d = S_GEN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GEN:  state_d = S_LOAD;
        S_LOAD: state_d = S_PLAY;
        S_PLAY: begin
          if (TimeUp) begin
            state_d = S_NEXT;
          end else if (Button) begin
            ans_d   = Answer;
            state_d = S_CHECK;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_CHECK: begin
          if (ans_q == Expected) begin
            score_d = sat_inc(score_q);
          end else begin
            score_d = score_q;
          end
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (strike_hit_s || (round_q == LAST_ROUND)) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 5'd1;
            state_d = S_GEN;
          end
        end
        S_DONE: begin
          if (Button) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    rng_d       = (state_d == S_GEN);
    load_d      = (state_d == S_LOAD);
    enable_d    = (state_d == S_PLAY);
    game_over_d = (state_d == S_DONE);
    correct_d   = (state_q == S_PLAY) && (state_d == S_CHECK) && (Answer == Expected);
    wrong_d     = ((state_q == S_PLAY) && (state_d == S_CHECK) && (Answer != Expected)) ||
                  ((state_q == S_PLAY) && (state_d == S_NEXT));
    logout_d    = (state_q == S_DONE) && (state_d == S_IDLE) && Access;
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      score_q     <= 5'd0;
      round_q     <= 5'd0;
      ans_q       <= 5'd0;
      rng_q       <= 1'b0;
      load_q      <= 1'b0;
      enable_q    <= 1'b0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      game_over_q <= 1'b0;
      logout_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      round_q     <= round_d;
      ans_q       <= ans_d;
      rng_q       <= rng_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      game_over_q <= game_over_d;
      logout_q    <= logout_d;
    end
  end

  assign RNGOut   = rng_q;
  assign LoadOut  = load_q;
  assign Enable   = enable_q;
  assign Correct  = correct_q;
  assign Wrong    = wrong_q;
  assign Score    = score_q;
  assign Round    = round_q;
  assign GameOver = game_over_q;
  assign LogOut   = logout_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: stimulus queues expected output events
// (kind, cycle, Score, Round); a negedge monitor pops and compares them.
module tb_round_sequencer;

  localparam int EV_RNG = 0, EV_LOAD = 1, EV_EN = 2, EV_OK = 3, EV_BAD = 4, EV_GO = 5, EV_LOGOUT = 6;
`ifdef STRIKE_LIMIT_EN
  localparam int B_LAST = 2;
`else
  localparam int B_LAST = 9;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic access_a, access_b, Button, TimeUp;
  logic [4:0] Answer, Expected;
  logic rng_a, load_a, en_a, ok_a, bad_a, go_a, lo_a;
  logic rng_b, load_b, en_b, ok_b, bad_b, go_b, lo_b;
  logic [4:0] score_a, round_a, score_b, round_b;

  always #5 Clock = ~Clock;

  round_sequencer #(.ROUNDS(3), .MAX_MISS(3)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .Access(access_a), .Button(Button), .Answer(Answer),
    .Expected(Expected), .TimeUp(TimeUp), .RNGOut(rng_a), .LoadOut(load_a), .Enable(en_a),
    .Correct(ok_a), .Wrong(bad_a), .Score(score_a), .Round(round_a), .GameOver(go_a), .LogOut(lo_a));

  round_sequencer #(.ROUNDS(10), .MAX_MISS(3)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .Access(access_b), .Button(Button), .Answer(Answer),
    .Expected(Expected), .TimeUp(TimeUp), .RNGOut(rng_b), .LoadOut(load_b), .Enable(en_b),
    .Correct(ok_b), .Wrong(bad_b), .Score(score_b), .Round(round_b), .GameOver(go_b), .LogOut(lo_b));

  typedef struct { int ev; int cyc; int score; int round; } exp_t;
  exp_t exp_q[$];
  int   ncyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   sel_b = 1'b0;
  logic en_prev_a = 1'b0, en_prev_b = 1'b0, go_prev_a = 1'b0, go_prev_b = 1'b0;

  function automatic string ev_name(input int ev);
    case (ev)
      EV_RNG:    return "RNGOut";
      EV_LOAD:   return "LoadOut";
      EV_EN:     return "Enable_rise";
      EV_OK:     return "Correct";
      EV_BAD:    return "Wrong";
      EV_GO:     return "GameOver_rise";
      EV_LOGOUT: return "LogOut";
      default:   return "none";
    endcase
  endfunction

  task automatic push(input int ev, input int cyc, input int sc, input int rd);
    exp_t e;
    e.ev = ev; e.cyc = cyc; e.score = sc; e.round = rd;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // Monitor: one event per cycle is possible in this design; compare against queue head.
  always @(negedge Clock) begin
    int ev;
    int sc;
    int rd;
    exp_t e;
    ncyc++;
    ev = -1;
    if (rng_a || rng_b) ev = EV_RNG;
    else if (load_a || load_b) ev = EV_LOAD;
    else if ((en_a && !en_prev_a) || (en_b && !en_prev_b)) ev = EV_EN;
    else if (ok_a || ok_b) ev = EV_OK;
    else if (bad_a || bad_b) ev = EV_BAD;
    else if ((go_a && !go_prev_a) || (go_b && !go_prev_b)) ev = EV_GO;
    else if (lo_a || lo_b) ev = EV_LOGOUT;
    en_prev_a = en_a; en_prev_b = en_b; go_prev_a = go_a; go_prev_b = go_b;
    sc = sel_b ? int'(score_b) : int'(score_a);
    rd = sel_b ? int'(round_b) : int'(round_a);
    if (ev >= 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: actual=%s cyc=%0d score=%0d round=%0d required=no event",
                 ev_name(ev), ncyc, sc, rd);
      end else begin
        e = exp_q.pop_front();
        if (e.ev == ev && e.cyc == ncyc && e.score == sc && e.round == rd) passes++;
        else $display("FAIL event: actual=%s cyc=%0d score=%0d round=%0d required=%s cyc=%0d score=%0d round=%0d",
                      ev_name(ev), ncyc, sc, rd, ev_name(e.ev), e.cyc, e.score, e.round);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  // Press Button in IDLE; returns in the first PLAY cycle.
  task automatic start_game();
    int n;
    n = ncyc;
    Button = 1'b1;
    push(EV_RNG, n + 1, 0, 0);
    push(EV_LOAD, n + 2, 0, 0);
    push(EV_EN, n + 3, 0, 0);
    step(1);
    Button = 1'b0;
    step(2);
  endtask

  // One question from the PLAY cycle; returns in the next PLAY cycle or the first DONE cycle.
  task automatic play_round(input bit tmo, input bit press, input logic [4:0] ans, input bit ok,
                            input int sc, input int rd, input bit last);
    int p;
    int d;
    int sc2;
    p   = ncyc;
    d   = tmo ? 1 : 2;
    sc2 = sc + ((!tmo && ok) ? 1 : 0);
    push((!tmo && ok) ? EV_OK : EV_BAD, p + 1, sc, rd);
    if (last) begin
      push(EV_GO, p + 1 + d, sc2, rd);
    end else begin
      push(EV_RNG, p + 1 + d, sc2, rd + 1);
      push(EV_LOAD, p + 2 + d, sc2, rd + 1);
      push(EV_EN, p + 3 + d, sc2, rd + 1);
    end
    TimeUp = tmo;
    Button = press;
    Answer = ans;
    step(1);
    TimeUp = 1'b0;
    Button = 1'b0;
    step(last ? d : d + 2);
  endtask

  function automatic int all_outs_a();
    return int'({rng_a, load_a, en_a, ok_a, bad_a, go_a, lo_a, score_a, round_a});
  endfunction

  function automatic int all_outs_b();
    return int'({rng_b, load_b, en_b, ok_b, bad_b, go_b, lo_b, score_b, round_b});
  endfunction

  initial begin
    int n;
    Button = 1'b0; TimeUp = 1'b0; Answer = 5'd0; Expected = 5'd9;
    access_a = 1'b0; access_b = 1'b0;
    #1 Reset = 1'b1;
    #2;
    chk("reset_outputs_a", all_outs_a(), 0);
    chk("reset_outputs_b", all_outs_b(), 0);
    step(2);
    Reset = 1'b0;
    step(1);

    // Game 1: correct, then TimeUp+Button tie, then access drop in round 2.
    access_a = 1'b1;
    start_game();
    play_round(1'b0, 1'b1, 5'd9, 1'b1, 0, 0, 1'b0);
    play_round(1'b1, 1'b1, 5'd9, 1'b1, 1, 1, 1'b0);
    access_a = 1'b0;
    step(1);
    chk("access_drop_enable", int'(en_a), 0);
    chk("access_drop_score_held", int'(score_a), 1);
    chk("access_drop_round_held", int'(round_a), 2);
    Button = 1'b1;
    step(1);
    Button = 1'b0;
    chk("no_start_without_access", int'(rng_a), 0);
    step(3);

    // Game 2: correct, wrong, correct over three rounds, then logout.
    access_a = 1'b1;
    start_game();
    play_round(1'b0, 1'b1, 5'd9, 1'b1, 0, 0, 1'b0);
    play_round(1'b0, 1'b1, 5'd3, 1'b0, 1, 1, 1'b0);
    play_round(1'b0, 1'b1, 5'd9, 1'b1, 1, 2, 1'b1);
    chk("done_gameover", int'(go_a), 1);
    chk("done_score", int'(score_a), 2);
    chk("done_round", int'(round_a), 2);
    n = ncyc;
    push(EV_LOGOUT, n + 1, 2, 2);
    Button = 1'b1;
    step(1);
    Button = 1'b0;
    chk("logout_gameover_clear", int'(go_a), 0);
    step(2);

    // Asynchronous reset while in LOAD, then restart.
    n = ncyc;
    push(EV_RNG, n + 1, 0, 0);
    Button = 1'b1;
    step(1);
    Button = 1'b0;
    @(posedge Clock);
    #2;
    chk("load_before_reset", int'(load_a), 1);
    Reset = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs_a(), 0);
    step(1);
    Reset = 1'b0;
    step(1);
    start_game();
    play_round(1'b0, 1'b1, 5'd9, 1'b1, 0, 0, 1'b0);
    access_a = 1'b0;
    step(2);

    // ROUNDS=10 instance: back-to-back timeouts.
    sel_b = 1'b1;
    access_b = 1'b1;
    start_game();
    for (int r = 0; r <= B_LAST; r++) begin
      play_round(1'b1, 1'b0, 5'd0, 1'b0, 0, r, (r == B_LAST));
    end
    chk("timeout_game_over", int'(go_b), 1);
    chk("timeout_final_round", int'(round_b), B_LAST);
    step(2);
    access_b = 1'b0;
    step(3);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL pending_events: actual=%0d outstanding required=0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
